// File: rtl/key_debouncer.sv
// Push-button conditioner: polarity fix, 2-flop synchronizer and per-key debounce
// counter, producing a clean active-high level plus one-cycle press/release strobes.
module key_debouncer #(
   parameter int KEYS_NUM        = 4,
   parameter int DEBOUNCE_CYCLES = 250000,
   parameter bit KEY_ACTIVE_LOW  = 1'b1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [KEYS_NUM-1:0] keys_raw,
   output logic [KEYS_NUM-1:0] keys_o,
   output logic [KEYS_NUM-1:0] keys_press,
   output logic [KEYS_NUM-1:0] keys_release
);

   localparam int              CW       = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic [KEYS_NUM-1:0] n;
   logic [KEYS_NUM-1:0] sync1;
   logic [KEYS_NUM-1:0] s;
   logic [CW-1:0]       cnt [KEYS_NUM];

   assign n = KEY_ACTIVE_LOW ? ~keys_raw : keys_raw;

   // keys_o is the stable state itself, so the strobes line up with its update
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1        <= '0;
         s            <= '0;
         keys_o       <= '0;
         keys_press   <= '0;
         keys_release <= '0;
         for (int i = 0; i < KEYS_NUM; i++) cnt[i] <= '0;
      end else begin
         sync1        <= n;
         s            <= sync1;
         keys_press   <= '0;
         keys_release <= '0;
         for (int i = 0; i < KEYS_NUM; i++) begin
            if (s[i] == keys_o[i]) begin
               cnt[i] <= '0;
            end else if (cnt[i] == CNT_LAST) begin
               keys_o[i]       <= s[i];
               keys_press[i]   <= s[i];
               keys_release[i] <= ~s[i];
               cnt[i]          <= '0;
            end else begin
               cnt[i] <= cnt[i] + CW'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_key_debouncer.sv
// Directed bench for key_debouncer with an 8-cycle debounce window; a second
// instance covers the active-high pin build.
module tb_key_debouncer;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] keys_raw;
   logic [3:0] keys_o, keys_press, keys_release;
   logic [3:0] keys_raw2;
   logic [3:0] keys_o2, keys_press2, keys_release2;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   key_debouncer #(.KEYS_NUM(4), .DEBOUNCE_CYCLES(8), .KEY_ACTIVE_LOW(1'b1)) dut (
      .clk(clk), .reset(reset), .keys_raw(keys_raw),
      .keys_o(keys_o), .keys_press(keys_press), .keys_release(keys_release)
   );

   key_debouncer #(.KEYS_NUM(4), .DEBOUNCE_CYCLES(8), .KEY_ACTIVE_LOW(1'b0)) dut_hi (
      .clk(clk), .reset(reset), .keys_raw(keys_raw2),
      .keys_o(keys_o2), .keys_press(keys_press2), .keys_release(keys_release2)
   );

   // Advance k rising edges, landing 1 time unit after the last one.
   task automatic step(input int k);
      repeat (k) @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_out(input string tag, input logic [3:0] o, input logic [3:0] p,
                            input logic [3:0] r);
      check({tag, " keys_o"}, keys_o, o);
      check({tag, " press"}, keys_press, p);
      check({tag, " release"}, keys_release, r);
   endtask

   initial begin
      reset     = 1'b1;
      keys_raw  = 4'hF;
      keys_raw2 = 4'h0;
      step(3);
      check_out("reset", 4'h0, 4'h0, 4'h0);
      reset = 1'b0;

      // idle, nothing pressed
      for (int i = 0; i < 20; i++) begin
         step(1);
         check_out("idle", 4'h0, 4'h0, 4'h0);
      end

      // key 0 press: accepted after edge 10
      keys_raw[0] = 1'b0;
      step(9);
      check_out("k0 edge9", 4'h0, 4'h0, 4'h0);
      step(1);
      check_out("k0 edge10", 4'h1, 4'h1, 4'h0);
      step(1);
      check_out("k0 edge11", 4'h1, 4'h0, 4'h0);

      // bounce toggling every 3 cycles never reaches the window
      for (int i = 0; i < 40; i++) begin
         keys_raw[0] = (((i / 3) % 2) == 0) ? 1'b1 : 1'b0;
         step(1);
         check_out("bounce", 4'h1, 4'h0, 4'h0);
      end
      keys_raw[0] = 1'b1;
      step(9);
      check_out("settle edge9", 4'h1, 4'h0, 4'h0);
      step(1);
      check_out("settle edge10", 4'h0, 4'h0, 4'h1);
      step(1);
      check_out("settle edge11", 4'h0, 4'h0, 4'h0);

      // key 1 low for 7 cycles: rejected
      keys_raw[1] = 1'b0;
      for (int i = 0; i < 7; i++) begin
         step(1);
         check_out("glitch7", 4'h0, 4'h0, 4'h0);
      end
      keys_raw[1] = 1'b1;
      for (int i = 0; i < 15; i++) begin
         step(1);
         check_out("glitch7 after", 4'h0, 4'h0, 4'h0);
      end

      // key 1 low for 8 cycles: accepted at edge 10, released at edge 18
      keys_raw[1] = 1'b0;
      step(8);
      keys_raw[1] = 1'b1;
      step(1);
      check_out("pulse8 edge9", 4'h0, 4'h0, 4'h0);
      step(1);
      check_out("pulse8 edge10", 4'h2, 4'h2, 4'h0);
      step(1);
      check_out("pulse8 edge11", 4'h2, 4'h0, 4'h0);
      step(7);
      check_out("pulse8 edge18", 4'h0, 4'h0, 4'h2);
      step(1);
      check_out("pulse8 edge19", 4'h0, 4'h0, 4'h0);
      step(5);

      // all keys together
      keys_raw = 4'h0;
      step(9);
      check_out("all edge9", 4'h0, 4'h0, 4'h0);
      step(1);
      check_out("all edge10", 4'hF, 4'hF, 4'h0);
      step(4);
      check_out("all held", 4'hF, 4'h0, 4'h0);

      // reset while held: clears without strobes
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step(1);
         check_out("reset held", 4'h0, 4'h0, 4'h0);
      end
      reset = 1'b0;
      step(9);
      check_out("post-reset edge9", 4'h0, 4'h0, 4'h0);
      step(1);
      check_out("post-reset edge10", 4'hF, 4'hF, 4'h0);
      step(1);
      check_out("post-reset edge11", 4'hF, 4'h0, 4'h0);

      // active-high pin build
      check("hi idle keys_o", keys_o2, 4'h0);
      keys_raw2[2] = 1'b1;
      step(9);
      check("hi edge9 keys_o", keys_o2, 4'h0);
      step(1);
      check("hi edge10 keys_o", keys_o2, 4'h4);
      check("hi edge10 press", keys_press2, 4'h4);
      check("hi edge10 release", keys_release2, 4'h0);
      step(1);
      check("hi edge11 press", keys_press2, 4'h0);
      check("hi edge11 keys_o", keys_o2, 4'h4);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
